// File: rtl/streebog_core_g.sv
// Streebog compression-function sequencer: g_N(h, m) = E(LPS(h ^ N), m) ^ h ^ m,
// driving an external LPS core through 2*ROUNDS+1 serial calls.
module streebog_core_g #(
  parameter int ROUNDS = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  output logic         rdy,
  input  logic [511:0] h_in,
  input  logic [511:0] n_in,
  input  logic [511:0] m_in,
  output logic [511:0] dout,
  output logic         lps_ena,
  input  logic         lps_rdy,
  output logic [511:0] lps_din,
  input  logic [511:0] lps_dout,
  output logic [3:0]   c_index,
  input  logic [511:0] c_value,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINAL} state_e;
  typedef enum logic [1:0] {KEY0, DATA, KEY} phase_e;

  localparam logic [3:0] LAST_R = 4'(ROUNDS - 1);

  state_e       state_q, state_d;
  phase_e       ph_q, ph_d;
  logic [3:0]   r_q, r_d;
  logic         rdy_q, rdy_d;
  logic [511:0] k_q, k_d;
  logic [511:0] s_q, s_d;
  logic [511:0] h_q, h_d;
  logic [511:0] m_q, m_d;
  logic [511:0] din_q, din_d;
  logic [511:0] dout_q, dout_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q    <= KEY0;
      r_q     <= '0;
      rdy_q   <= 1'b1;
      k_q     <= '0;
      s_q     <= '0;
      h_q     <= '0;
      m_q     <= '0;
      din_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      r_q     <= r_d;
      rdy_q   <= rdy_d;
      k_q     <= k_d;
      s_q     <= s_d;
      h_q     <= h_d;
      m_q     <= m_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
    end
  end

  // din_q only moves on a capture, so lps_din stays constant for the whole
  // LPS call; the core re-reads its input on every internal stage.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    r_d     = r_q;
    rdy_d   = rdy_q;
    k_d     = k_q;
    s_d     = s_q;
    h_d     = h_q;
    m_d     = m_q;
    din_d   = din_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (ena && rdy_q) begin
          h_d     = h_in;
          m_d     = m_in;
          s_d     = m_in;
          din_d   = h_in ^ n_in;
          ph_d    = KEY0;
          r_d     = '0;
          rdy_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (lps_rdy) state_d = WAIT;
      end
      WAIT: begin
        if (lps_rdy) begin
          case (ph_q)
            KEY0: begin
              k_d     = lps_dout;
              din_d   = lps_dout ^ s_q;
              ph_d    = DATA;
              state_d = ISSUE;
            end
            DATA: begin
              s_d     = lps_dout;
              din_d   = k_q ^ c_value;
              ph_d    = KEY;
              state_d = ISSUE;
            end
            default: begin
              if (r_q == LAST_R) begin
                dout_d  = lps_dout ^ s_q ^ h_q ^ m_q;
                state_d = FINAL;
              end else begin
                k_d     = lps_dout;
                din_d   = lps_dout ^ s_q;
                r_d     = r_q + 4'd1;
                ph_d    = DATA;
                state_d = ISSUE;
              end
            end
          endcase
        end
      end
      default: begin
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Strobe only when the core can take it, so a core still finishing an
  // orphaned call (controller reset mid-run) just stalls us in ISSUE.
  assign lps_ena   = (state_q == ISSUE) && lps_rdy;
  assign lps_din   = din_q;
  assign c_index   = r_q;
  assign rdy       = rdy_q;
  assign dout      = dout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_streebog_core_g.sv
// Directed bench for streebog_core_g with a 4-cycle LPS stub (identity or
// rotate-plus-add) and a one-cycle-latency round-constant ROM.
module tb_streebog_core_g;

  logic         clk = 1'b0;
  logic         rst_n, stub_rst_n;
  logic         ena;
  logic         rdy;
  logic [511:0] h_in, n_in, m_in, dout;
  logic         lps_ena;
  logic         s_rdy;
  logic [511:0] lps_din, s_dout;
  logic [3:0]   c_index;
  logic [511:0] c_value;
  logic [1:0]   dbg_state;
  logic [2:0]   s_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int base     = 0;
  int call_j   = 0;
  int stub_mode = 0;
  int c_mode    = 0;
  logic [511:0] exp_q[$];
  int pulses[$];

  streebog_core_g #(.ROUNDS(12)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rdy(rdy),
    .h_in(h_in), .n_in(n_in), .m_in(m_in), .dout(dout),
    .lps_ena(lps_ena), .lps_rdy(s_rdy), .lps_din(lps_din), .lps_dout(s_dout),
    .c_index(c_index), .c_value(c_value), .dbg_state(dbg_state)
  );

  // clock / reset-free cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [511:0] stub_f(input logic [511:0] x, input int mode);
    if (mode == 0) return x;
    return {x[502:0], x[511:503]} + 512'h1234_5678_9abc_def1;
  endfunction

  function automatic logic [511:0] c_fn(input logic [3:0] idx, input int mode);
    logic [7:0]  b;
    logic [31:0] w;
    b = {4'h0, idx};
    w = 32'h9e3779b9 * (32'(idx) + 32'd1);
    if (mode == 0) return '0;
    if (mode == 1) return {64{b}};
    return {16{w}};
  endfunction

  // LPS stub: busy 4 cycles, re-reads lps_din on every busy cycle
  always @(posedge clk) begin
    if (!stub_rst_n) begin
      s_rdy <= 1'b1; s_cnt <= '0; s_dout <= '0;
    end else if (lps_ena && s_rdy) begin
      s_rdy <= 1'b0; s_cnt <= 3'd4; s_dout <= stub_f(lps_din, stub_mode);
    end else if (!s_rdy) begin
      s_dout <= stub_f(lps_din, stub_mode);
      if (s_cnt == 3'd1) begin s_rdy <= 1'b1; s_cnt <= '0; end
      else s_cnt <= s_cnt - 3'd1;
    end
  end

  always @(posedge clk) c_value <= c_fn(c_index, c_mode);

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard: every strobe checked against the model's call sequence
  always @(negedge clk) begin
    if (lps_ena) begin
      check("strobe_when_lps_rdy", 512'(s_rdy), 512'(1));
      pulses.push_back(cyc - base);
      if (exp_q.size() != 0) check("lps_din", lps_din, exp_q.pop_front());
      check("c_index", 512'(c_index), 512'((call_j == 0) ? 0 : (call_j - 1) / 2));
      call_j++;
    end
  end

  task automatic build_model(input logic [511:0] h, n, m, input int smode, cmode,
                             output logic [511:0] res);
    logic [511:0] k, s, d;
    exp_q.delete();
    d = h ^ n; exp_q.push_back(d); k = stub_f(d, smode); s = m;
    for (int r = 0; r < 12; r++) begin
      d = k ^ s;                    exp_q.push_back(d); s = stub_f(d, smode);
      d = k ^ c_fn(4'(r), cmode);   exp_q.push_back(d); k = stub_f(d, smode);
    end
    res = k ^ s ^ h ^ m;
  endtask

  // Starts a run at the current negedge. abort_rel>0 pulses rst_n at that cycle.
  task automatic run(input logic [511:0] h, n, m, input int smode, cmode,
                     input int ena1, ena2, abort_rel, stall,
                     input bit use_hand, input logic [511:0] hand);
    logic [511:0] res;
    int rel;
    bit done;
    build_model(h, n, m, smode, cmode, res);
    if (use_hand) res = hand;
    stub_mode = smode; c_mode = cmode;
    pulses.delete(); call_j = 0;
    h_in = h; n_in = n; m_in = m; ena = 1'b1; base = cyc;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      rel = cyc - base;
      ena = (rel == ena1 || rel == ena2);
      h_in = {16{$urandom}}; n_in = {16{$urandom}}; m_in = {16{$urandom}};
      if (abort_rel != 0 && rel == abort_rel) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_dout", dout, '0);
        check("abort_rdy", 512'(rdy), 512'(1));
        check("abort_lps_din", lps_din, '0);
        return;
      end
      if (rdy) done = 1'b1;
    end
    ena = 1'b0;
    check("run_finished", 512'(done), 512'(1));
    check("rdy_cycle", 512'(rel), 512'(152 + stall));
    check("dout", dout, res);
    check("pulse_count", 512'(pulses.size()), 512'(25));
    for (int j = 0; j < pulses.size() && j < 25; j++)
      check($sformatf("pulse_cycle_%0d", j), 512'(pulses[j]), 512'(1 + stall + 6 * j));
  endtask

  localparam logic [511:0] H_A = {64{8'h11}};
  localparam logic [511:0] M_A = {64{8'hAB}};
  localparam logic [511:0] H_D = {8{64'h0123456789abcdef}};
  localparam logic [511:0] M_D = {16{32'hdeadbeef}};

  initial begin
    rst_n = 1'b0; stub_rst_n = 1'b0; ena = 1'b0;
    h_in = '0; n_in = '0; m_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; stub_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_rdy", 512'(rdy), 512'(1));
      check("idle_dout", dout, '0);
      check("idle_lps_ena", 512'(lps_ena), 512'(0));
      check("idle_c_index", 512'(c_index), 512'(0));
      check("idle_state", 512'(dbg_state), 512'(0));
    end
    // identity LPS, zero constants: g reduces to n_in
    run(H_A, 512'h200, M_A, 0, 0, -1, -1, 0, 0, 1'b1, 512'h200);
    repeat (3) @(negedge clk);
    check("dout_hold", dout, 512'h200);
    check("rdy_hold", 512'(rdy), 512'(1));
    // per-round constants visible through c_index / lps_din
    run(H_A, 512'h200, M_A, 0, 1, -1, -1, 0, 0, 1'b0, '0);
    // nonlinear stub, registered ROM with distinct constants
    run(H_D, 512'h400, M_D, 1, 2, -1, -1, 0, 0, 1'b0, '0);
    // ena while busy is ignored
    run(H_A, 512'h200, M_A, 0, 0, 10, 100, 0, 0, 1'b1, 512'h200);
    // reset at cycle 40 (stub busy until 41), restart next cycle: no stall
    run(H_D, 512'h400, M_D, 1, 2, -1, -1, 40, 0, 1'b0, '0);
    run(H_D, 512'h400, M_D, 1, 2, -1, -1, 0, 0, 1'b0, '0);
    // reset at cycle 38: restart stalls two cycles on the orphaned call
    run(H_A, 512'h200, M_A, 0, 1, -1, -1, 38, 0, 1'b0, '0);
    run(H_A, 512'h200, M_A, 0, 1, -1, -1, 0, 2, 1'b0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
